// File: rtl/traffic_generator.sv
// Synthetic single-flit packet source for one PE: paces requests on the router
// Local port with Req/Gnt/Full and exposes a per-grant send log on its outputs.
module traffic_generator #(
    parameter logic [5:0]  routerID       = 6'b000_000,
    parameter logic [5:0]  ModuleID       = 6'b000_000,
    parameter int          dataWidth      = 32,
    parameter int          dim            = 4,
    parameter int          numPackets     = 100,
    parameter int          injectInterval = 8,
    parameter int          destMode       = 0,
    parameter logic [5:0]  DestID         = 6'b000_001,
    parameter logic [15:0] lfsrSeed       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [dataWidth-1:0] PacketOut,
    output logic                 ReqDnStr,
    input  logic                 GntDnStr,
    input  logic                 DnStrFull,
    output logic                 Done,
    output logic [15:0]          SentCount,
    output logic                 LogValid,
    output logic [31:0]          LogCycle,
    output logic [5:0]           LogRouterID,
    output logic [15:0]          StallCount
);

    localparam logic [1:0] GAP  = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] NUM    = 32'(numPackets);
    localparam logic [15:0] RELOAD = 16'(injectInterval - 1);

    logic [1:0]           state_q, state_d;
    logic [dataWidth-1:0] pkt_q, pkt_d;
    logic                 req_q, req_d;
    logic [15:0]          sent_q, sent_d;
    logic [9:0]           pid_q, pid_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [31:0]          cycle_q, cycle_d;
    logic [15:0]          stall_q, stall_d;
    logic                 log_valid_q, log_valid_d;
    logic [31:0]          log_cycle_q, log_cycle_d;
    logic [5:0]           cur_dest;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Fibonacci taps 16,14,13,11 for a left shift land on bits 15,13,12,10.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [5:0] rand_dest(input logic [15:0] l);
        logic [2:0] x;
        logic [2:0] y;
        x = 3'(int'(l[2:0]) % dim);
        y = 3'(int'(l[5:3]) % dim);
        if ({x, y} == ModuleID)
            x = 3'((int'(x) + 1) % dim);
        return {x, y};
    endfunction

    function automatic logic [dataWidth-1:0] pack(input logic [9:0] id, input logic [5:0] dst);
        logic [dataWidth-1:0] p;
        p        = '0;
        p[21:16] = dst;
        p[15:6]  = id;
        p[5:0]   = ModuleID;
        return p;
    endfunction

    assign cur_dest = (destMode == 1) ? rand_dest(lfsr_q) : DestID;

    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        req_d       = req_q;
        sent_d      = sent_q;
        pid_d       = pid_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        stall_d     = stall_q;
        log_cycle_d = log_cycle_q;
        log_valid_d = 1'b0;
        cycle_d     = cycle_q + 32'd1;

        case (state_q)
            GAP: begin
                if (32'(sent_q) >= NUM) begin
                    state_d = DONE;
                end else if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (DnStrFull) begin
                    stall_d = sat_inc(stall_q);
                end else begin
                    pkt_d       = pack(pid_q, cur_dest);
                    req_d       = 1'b1;
                    log_cycle_d = cycle_q;
                    state_d     = REQ;
                end
            end
            // A raised request is never withdrawn; Full is ignored until the grant.
            REQ: begin
                if (GntDnStr) begin
                    req_d       = 1'b0;
                    sent_d      = sat_inc(sent_q);
                    pid_d       = pid_q + 10'd1;
                    cnt_d       = RELOAD;
                    lfsr_d      = lfsr_next(lfsr_q);
                    log_valid_d = 1'b1;
                    state_d     = (32'(sent_d) == NUM) ? DONE : GAP;
                end
            end
            DONE: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = GAP;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= GAP;
            pkt_q       <= '0;
            req_q       <= 1'b0;
            sent_q      <= 16'd0;
            pid_q       <= 10'd0;
            cnt_q       <= 16'd0;
            lfsr_q      <= lfsrSeed;
            cycle_q     <= 32'd0;
            stall_q     <= 16'd0;
            log_valid_q <= 1'b0;
            log_cycle_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            req_q       <= req_d;
            sent_q      <= sent_d;
            pid_q       <= pid_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            cycle_q     <= cycle_d;
            stall_q     <= stall_d;
            log_valid_q <= log_valid_d;
            log_cycle_q <= log_cycle_d;
        end
    end

    assign PacketOut   = pkt_q;
    assign ReqDnStr    = req_q;
    assign Done        = (state_q == DONE);
    assign SentCount   = sent_q;
    assign LogValid    = log_valid_q;
    assign LogCycle    = log_cycle_q;
    assign LogRouterID = routerID;
    assign StallCount  = stall_q;

endmodule
